trap_unit: RTL and testbench
============================

# trap_unit

Machine-mode trap unit for the single-cycle RV32 core. It owns the memory-mapped machine timer, the sticky timer-pending flag, the global interrupt enable and `mepc`. It drives `timerInterrupt` into the controller and sequences the trap-entry / `mret` handshake. It sits beside the data memory on the store/load bus and feeds `mepc` to the PC mux.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_1000: base of the 16-byte MMIO window.
- `CMP_RESET`, default 32'hFFFF_FFFF: reset value of `mtimecmp`.

Ports (clock and reset first):
- `clk` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `pc` in 32: address of the instruction executing this cycle.
- `csrWriteEnable` in 1: controller trap-entry strobe.
- `isReturn` in 1: controller `mret` strobe.
- `busAddress` in 32: ALU address from `lw`/`sw`.
- `busWriteData` in 32: store data.
- `busWriteEnable` in 1: `memoryWriteEnable` from the controller.
- `busSelect` out 1: address falls in `BASE_ADDR`..`BASE_ADDR+15`; the top level steers load data and suppresses the RAM write.
- `busReadData` out 32: MMIO read data.
- `timerInterrupt` out 1: interrupt request to the controller.
- `mepc` out 32: saved return PC.
- `inHandler` out 1: high while state is HANDLER.

## Operation
MMIO word offsets (`busAddress[3:2]`); byte offsets ignored:
- 0: `mtime`, RW.
- 4: `mtimecmp`, RW.
- 8: `control`, RW. Bit0 = MIE, bit1 = TEN (timer enable); other bits read 0.
- 12: `mepc`, RO; writes are ignored.

Timer and pending flag:
- `mtime` increments by 1 each cycle while TEN=1. It wraps from 32'hFFFF_FFFF to 0 with no flag.
- `pending` is set when TEN=1 and `mtime == mtimecmp`. The compare uses register values before this edge's update.
- `pending` is cleared on trap entry or on any bus write to `mtimecmp`.

Interrupt request:
- `timerInterrupt = pending & MIE & (state == RUN)`.
- It is a function of registers only, with no combinational path from inputs.

State machine (two states, RUN and HANDLER):
- RUN→HANDLER when `csrWriteEnable & timerInterrupt`. On that edge: `mepc <= pc`, `MPIE <= MIE`, `MIE <= 0`, `pending <= 0`.
- HANDLER→RUN when `isReturn`. On that edge: `MIE <= MPIE`, `MPIE <= 1`.
- `csrWriteEnable` while `timerInterrupt` is 0 is ignored.
- `isReturn` in RUN is ignored; no register changes.

Simultaneous events (priority, highest first):
- Trap entry over a bus write to `control`: MIE ends 0, TEN takes the written value.
- Bus write to `mtime` over the increment.
- Bus write to `mtimecmp` clears `pending`, even if a match occurs the same cycle.
- A new match on the trap-entry edge: set wins, so `pending` ends 1.
- `isReturn` with a bus write to `control` in HANDLER: MIE ends at MPIE, TEN takes the written value.

Reset values:
- Registers: `mtime`=0, `mtimecmp`=`CMP_RESET`, `control`=0, `MPIE`=0, `pending`=0, `mepc`=0, state RUN.
- Outputs: `timerInterrupt`=0, `inHandler`=0, `mepc`=0.
- `busReadData` and `busSelect` are combinational (see Timing) and remain address-dependent during reset.
- Reset asserted mid-handler returns to RUN immediately (asynchronous).

## Timing
- `busReadData` and `busSelect` are combinational from `busAddress` and registers: zero-latency load path. `busReadData` is 0 when `busSelect`=0.
- A write lands on the edge and is visible to reads the next cycle.
- Match at cycle N (`mtime==mtimecmp` before edge N) → `pending` and `timerInterrupt` high in cycle N+1 → trap taken at the end of N+1 → `mepc` = `pc` of cycle N+1, `inHandler` high from N+2.
- `mret` in cycle M → `inHandler` low and MIE restored from M+1. `timerInterrupt` can re-assert in M+1 if `pending` is already set.

## Structure
- Package `trap_pkg`:
  - offset constants `OFF_MTIME`, `OFF_MTIMECMP`, `OFF_CONTROL`, `OFF_MEPC`;
  - control bit indices `CTRL_MIE`, `CTRL_TEN`;
  - `trap_state_t` enum {RUN, HANDLER}.
- Sub-module `machine_timer`: contains `mtime`, `mtimecmp`, the TEN-gated increment and the `pending` flag. Inputs: the decoded writes and `clearPending`.
- `trap_unit`: decode, `control`/`MPIE`/`mepc`, state machine and read mux.

## Test plan
- Reset: hold `reset`, then release → all reads 0 except `mtimecmp`=32'hFFFF_FFFF; `timerInterrupt`=0.
- Basic trap: write `mtimecmp`=5, then `control`=3 → `timerInterrupt` rises exactly one cycle after `mtime` reads 5. With `pc`=32'h40 and `csrWriteEnable` → `mepc`=32'h40, `inHandler`=1, MIE=0.
- Masking: run with `control`=2 (MIE=0) to the match → `pending` set, no request. Write `control`=3 → request the next cycle.
- Return: `isReturn` in HANDLER → `control` reads 3 and `inHandler`=0. A second `isReturn` in RUN → no change.
- Priority: write `mtimecmp` in the match cycle → `pending` stays 0. Set `mtime`=32'hFFFF_FFFF with `mtimecmp`=0 → wraps and matches one cycle later.
- Async reset in HANDLER: pulse `reset` mid-cycle → `inHandler`, `mepc` and `timerInterrupt` go to 0 before the next edge.

Source files
------------

// File: rtl/trap_pkg.sv
// trap_pkg: shared constants and types for the machine-mode trap unit.
//   OFF_*        : MMIO word offsets, compared against busAddress[3:2]
//   CTRL_*       : bit positions inside the control register
//   trap_state_t : trap state machine encoding
package trap_pkg;

    localparam logic [1:0] OFF_MTIME    = 2'd0;
    localparam logic [1:0] OFF_MTIMECMP = 2'd1;
    localparam logic [1:0] OFF_CONTROL  = 2'd2;
    localparam logic [1:0] OFF_MEPC     = 2'd3;

    localparam int CTRL_MIE = 0;
    localparam int CTRL_TEN = 1;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } trap_state_t;

endpackage

// File: rtl/machine_timer.sv
// machine_timer: free-running machine timer with compare and sticky pending flag.
// Ports:
//   clk, reset          : core clock, asynchronous active-high reset
//   i_ten               : timer enable (counts and compares only while set)
//   i_wr_mtime          : bus write strobe for mtime
//   i_wr_mtimecmp       : bus write strobe for mtimecmp (also clears pending)
//   i_wdata             : bus write data
//   i_clear_pending     : trap-entry strobe, clears pending unless a new match sets it
//   o_mtime, o_mtimecmp : current register values for the read mux
//   o_pending           : sticky timer-pending flag
module machine_timer #(
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ten,
    input  logic        i_wr_mtime,
    input  logic        i_wr_mtimecmp,
    input  logic [31:0] i_wdata,
    input  logic        i_clear_pending,
    output logic [31:0] o_mtime,
    output logic [31:0] o_mtimecmp,
    output logic        o_pending
);

    logic [31:0] r_mtime;
    logic [31:0] r_mtimecmp;
    logic        r_pending;
    logic        w_match;

    // Compare uses the values held before this edge's update.
    assign w_match = i_ten && (r_mtime == r_mtimecmp);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, which the compare and priority rules rely on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mtime    <= '0;
            r_mtimecmp <= CMP_RESET;
            r_pending  <= 1'b0;
        end else begin
            // A bus write to mtime overrides the increment; wrap is silent.
            if (i_wr_mtime)
                r_mtime <= i_wdata;
            else if (i_ten)
                r_mtime <= r_mtime + 32'd1;

            if (i_wr_mtimecmp)
                r_mtimecmp <= i_wdata;

            // Priority: compare-register write clears, then a fresh match sets,
            // then trap entry clears.
            if (i_wr_mtimecmp)
                r_pending <= 1'b0;
            else if (w_match)
                r_pending <= 1'b1;
            else if (i_clear_pending)
                r_pending <= 1'b0;
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_pending  = r_pending;

endmodule

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap unit for the single-cycle RV32 core.
// Owns the MMIO timer window, control (MIE/TEN), MPIE, mepc and the
// RUN/HANDLER state machine.
// Ports:
//   clk, reset      : core clock, asynchronous active-high reset
//   pc              : PC of the instruction executing this cycle
//   csrWriteEnable  : controller trap-entry strobe
//   isReturn        : controller mret strobe
//   busAddress      : load/store address
//   busWriteData    : store data
//   busWriteEnable  : store strobe
//   busSelect       : address hits the 16-byte MMIO window
//   busReadData     : combinational MMIO read data (0 outside the window)
//   timerInterrupt  : interrupt request to the controller
//   mepc            : saved return PC
//   inHandler       : high while in HANDLER
module trap_unit
    import trap_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        csrWriteEnable,
    input  logic        isReturn,
    input  logic [31:0] busAddress,
    input  logic [31:0] busWriteData,
    input  logic        busWriteEnable,
    output logic        busSelect,
    output logic [31:0] busReadData,
    output logic        timerInterrupt,
    output logic [31:0] mepc,
    output logic        inHandler
);

    trap_state_t r_state;
    logic        r_mie;
    logic        r_ten;
    logic        r_mpie;
    logic [31:0] r_mepc;

    logic [1:0]  w_offset;
    logic        w_write;
    logic        w_wr_mtime;
    logic        w_wr_mtimecmp;
    logic        w_wr_control;
    logic        w_trap_entry;
    logic [31:0] w_mtime;
    logic [31:0] w_mtimecmp;
    logic        w_pending;
    logic        w_unused_addr;

    // Byte offsets inside a word are ignored.
    assign w_unused_addr = ^busAddress[1:0];

    assign busSelect     = (busAddress[31:4] == BASE_ADDR[31:4]);
    assign w_offset      = busAddress[3:2];
    assign w_write       = busSelect & busWriteEnable;
    assign w_wr_mtime    = w_write && (w_offset == OFF_MTIME);
    assign w_wr_mtimecmp = w_write && (w_offset == OFF_MTIMECMP);
    assign w_wr_control  = w_write && (w_offset == OFF_CONTROL);

    // Request depends on registers only, so the controller sees no input-to-output path.
    assign timerInterrupt = w_pending & r_mie & (r_state == RUN);
    assign w_trap_entry   = csrWriteEnable & timerInterrupt;

    machine_timer #(
        .CMP_RESET(CMP_RESET)
    ) u_timer (
        .clk            (clk),
        .reset          (reset),
        .i_ten          (r_ten),
        .i_wr_mtime     (w_wr_mtime),
        .i_wr_mtimecmp  (w_wr_mtimecmp),
        .i_wdata        (busWriteData),
        .i_clear_pending(w_trap_entry),
        .o_mtime        (w_mtime),
        .o_mtimecmp     (w_mtimecmp),
        .o_pending      (w_pending)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_mie   <= 1'b0;
            r_ten   <= 1'b0;
            r_mpie  <= 1'b0;
            r_mepc  <= '0;
        end else begin
            if (w_wr_control) begin
                r_mie <= busWriteData[CTRL_MIE];
                r_ten <= busWriteData[CTRL_TEN];
            end
            // Trap entry and mret come after the control write so their MIE
            // update wins while TEN keeps the written value.
            case (r_state)
                RUN: begin
                    if (w_trap_entry) begin
                        r_state <= HANDLER;
                        r_mepc  <= pc;
                        r_mpie  <= r_mie;
                        r_mie   <= 1'b0;
                    end
                end
                HANDLER: begin
                    if (isReturn) begin
                        r_state <= RUN;
                        r_mie   <= r_mpie;
                        r_mpie  <= 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign mepc      = r_mepc;
    assign inHandler = (r_state == HANDLER);

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        busReadData = '0;
        if (busSelect) begin
            case (w_offset)
                OFF_MTIME:    busReadData = w_mtime;
                OFF_MTIMECMP: busReadData = w_mtimecmp;
                OFF_CONTROL: begin
                    busReadData[CTRL_MIE] = r_mie;
                    busReadData[CTRL_TEN] = r_ten;
                end
                OFF_MEPC:     busReadData = r_mepc;
                default:      busReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed plus randomized bench for trap_unit, checked against
// a behavioural model of the timer/trap rules kept in this file.
module tb_trap_unit;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        csrWriteEnable;
    logic        isReturn;
    logic [31:0] busAddress;
    logic [31:0] busWriteData;
    logic        busWriteEnable;
    logic        busSelect;
    logic [31:0] busReadData;
    logic        timerInterrupt;
    logic [31:0] mepc;
    logic        inHandler;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the architectural state.
    logic [31:0] m_mtime, m_cmp, m_mepc;
    logic        m_mie, m_ten, m_mpie, m_pending, m_inh;

    trap_unit #(
        .BASE_ADDR(BASE),
        .CMP_RESET(32'hFFFF_FFFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .csrWriteEnable(csrWriteEnable),
        .isReturn      (isReturn),
        .busAddress    (busAddress),
        .busWriteData  (busWriteData),
        .busWriteEnable(busWriteEnable),
        .busSelect     (busSelect),
        .busReadData   (busReadData),
        .timerInterrupt(timerInterrupt),
        .mepc          (mepc),
        .inHandler     (inHandler)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime = 0; m_cmp = 32'hFFFF_FFFF; m_mepc = 0;
        m_mie = 0; m_ten = 0; m_mpie = 0; m_pending = 0; m_inh = 0;
    endtask

    function automatic logic model_sel(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd15);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!model_sel(a)) return 32'd0;
        case ((a - BASE) / 4)
            0: return m_mtime;
            1: return m_cmp;
            2: return {30'd0, m_ten, m_mie};
            default: return m_mepc;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_pending && m_mie && !m_inh;
    endfunction

    task automatic idle();
        csrWriteEnable = 0; isReturn = 0; busWriteEnable = 0;
        busWriteData = 0; busAddress = BASE;
    endtask

    // One clock: check combinational bus outputs, advance the model by the
    // architectural rules, then check the registered outputs after the edge.
    task automatic cycle();
        int          word;
        logic        wr, trap, ret, match;
        logic [31:0] n_mtime, n_cmp, n_mepc;
        logic        n_mie, n_ten, n_mpie, n_pending, n_inh;
        #1;
        check("busSelect", busSelect, model_sel(busAddress));
        check("busReadData", busReadData, model_read(busAddress));
        wr    = busWriteEnable && model_sel(busAddress);
        word  = int'((busAddress - BASE) / 4);
        match = m_ten && (m_mtime == m_cmp);
        trap  = csrWriteEnable && model_irq();
        ret   = isReturn && m_inh;
        n_mtime   = (wr && word == 0) ? busWriteData : (m_ten ? m_mtime + 1 : m_mtime);
        n_cmp     = (wr && word == 1) ? busWriteData : m_cmp;
        n_pending = (wr && word == 1) ? 1'b0 : (match ? 1'b1 : (trap ? 1'b0 : m_pending));
        n_mie = m_mie; n_ten = m_ten;
        if (wr && word == 2) begin n_mie = busWriteData[0]; n_ten = busWriteData[1]; end
        if (trap) n_mie = 1'b0;
        if (ret)  n_mie = m_mpie;
        n_mpie = trap ? m_mie : (ret ? 1'b1 : m_mpie);
        n_mepc = trap ? pc : m_mepc;
        n_inh  = trap ? 1'b1 : (ret ? 1'b0 : m_inh);
        @(posedge clk); #1;
        m_mtime = n_mtime; m_cmp = n_cmp; m_pending = n_pending; m_mie = n_mie;
        m_ten = n_ten; m_mpie = n_mpie; m_mepc = n_mepc; m_inh = n_inh;
        check("timerInterrupt", timerInterrupt, model_irq());
        check("inHandler", inHandler, m_inh);
        check("mepc", mepc, m_mepc);
        @(negedge clk);
    endtask

    task automatic wr(input int word, input logic [31:0] data);
        idle();
        busAddress = BASE + 32'(word * 4); busWriteData = data; busWriteEnable = 1;
        cycle();
        idle();
    endtask

    task automatic rd(input string tag, input int word, input logic [31:0] exp);
        idle();
        busAddress = BASE + 32'(word * 4);
        #1;
        check(tag, busReadData, exp);
    endtask

    initial begin
        logic done;
        int   r, word;
        logic [31:0] v;

        idle(); pc = 0; reset = 1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_irq", timerInterrupt, 0);
        check("rst_inh", inHandler, 0);
        check("rst_mepc", mepc, 0);
        rd("rst_mtime", 0, 32'h0);
        rd("rst_cmp", 1, 32'hFFFF_FFFF);
        rd("rst_ctrl", 2, 32'h0);
        rd("rst_mepc_rd", 3, 32'h0);
        busAddress = 32'h0000_2004; #1;
        check("outside_sel", busSelect, 0);
        check("outside_rd", busReadData, 0);
        @(negedge clk); reset = 0;

        // Basic trap: compare at 5, then enable timer and interrupts.
        wr(1, 32'd5);
        wr(2, 32'd3);
        done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            pc = 32'h40; csrWriteEnable = 1; busAddress = BASE;
            cycle();
            done = m_inh;
        end
        idle();
        check("trap_taken", inHandler, 1);
        check("trap_mepc", mepc, 32'h40);
        rd("trap_ctrl", 2, 32'h2);
        rd("trap_mepc_rd", 3, 32'h40);

        // Return, then a second mret in RUN changes nothing.
        isReturn = 1; cycle(); idle();
        rd("ret_ctrl", 2, 32'h3);
        check("ret_inh", inHandler, 0);
        isReturn = 1; cycle(); idle();
        rd("ret2_ctrl", 2, 32'h3);
        check("ret2_inh", inHandler, 0);

        // Masking: pending latches with MIE=0, request appears once MIE is set.
        wr(2, 32'd2);
        wr(1, 32'd10);
        wr(0, 32'd0);
        repeat (15) cycle();
        check("mask_no_irq", timerInterrupt, 0);
        wr(2, 32'd3);
        check("unmask_irq", timerInterrupt, 1);
        pc = 32'h44; csrWriteEnable = 1; cycle(); idle();
        check("mask_trap", mepc, 32'h44);
        isReturn = 1; cycle(); idle();

        // Compare-register write in the match cycle keeps pending clear.
        wr(1, 32'd103);
        wr(0, 32'd100);
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            if (m_mtime == m_cmp) begin
                busAddress = BASE + 4; busWriteData = 32'd200; busWriteEnable = 1;
                done = 1;
            end
            cycle(); idle();
        end
        check("prio_reached", done, 1);
        check("prio_no_irq", timerInterrupt, 0);

        // Wrap: FFFF_FFFF -> 0 matches mtimecmp=0 one cycle later.
        wr(1, 32'd0);
        wr(0, 32'hFFFF_FFFF);
        cycle();
        check("wrap_pre", timerInterrupt, 0);
        cycle();
        check("wrap_irq", timerInterrupt, 1);
        pc = 32'h48; csrWriteEnable = 1; cycle(); idle();
        isReturn = 1; cycle(); idle();

        // Randomized traffic, small timer values so matches are frequent.
        for (int k = 0; k < 300; k++) begin
            pc = $urandom;
            csrWriteEnable = ($urandom_range(0, 3) == 0);
            isReturn       = ($urandom_range(0, 3) == 0);
            busWriteEnable = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            word = $urandom_range(0, 3);
            busAddress = (r < 2) ? $urandom : BASE + 32'(word * 4) + 32'($urandom_range(0, 3));
            v = $urandom;
            case (word)
                0, 1:    busWriteData = 32'($urandom_range(0, 30));
                2:       busWriteData = (v & 32'hFFFF_FFF0) | 32'($urandom_range(0, 3));
                default: busWriteData = v;
            endcase
            cycle();
        end
        idle();

        // Async reset while in HANDLER.
        isReturn = 1; cycle(); idle();
        wr(2, 32'd3);
        wr(1, 32'd2);
        wr(0, 32'd0);
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            pc = 32'h80; csrWriteEnable = 1; busAddress = BASE;
            cycle();
            done = m_inh;
        end
        idle();
        check("pre_rst_inh", inHandler, 1);
        check("pre_rst_mepc", mepc, 32'h80);
        #2 reset = 1;
        #1;
        model_reset();
        check("arst_inh", inHandler, 0);
        check("arst_mepc", mepc, 0);
        check("arst_irq", timerInterrupt, 0);
        #1 reset = 0;
        @(negedge clk);
        rd("post_rst_ctrl", 2, 32'h0);
        rd("post_rst_cmp", 1, 32'hFFFF_FFFF);
        rd("post_rst_mtime", 0, 32'h0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
